// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage downstream of alu_stage.
// Performs byte/word loads and stores over a req/ack bus, stalls upstream
// while a transaction is in flight, and emits one result beat per instruction.
// Ports:
//   clk, rst                 clock, async active-high reset
//   en, stall                upstream valid in, busy out (stall = WAIT state)
//   pc_in, control_signals_in, alu_result_in, wdata_in   instruction payload
//   mem_rb/rw/wb/ww          byte read, word read, byte write, word write
//   bus_req/we/addr/wdata/wstrb, bus_rdata/bus_ack        data bus
//   valid_out, result_out, control_signals_out, pc_out, fault_out  to writeback
module mem_stage #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic        stall,
   input  logic [15:0] pc_in,
   input  logic [31:0] control_signals_in,
   input  logic [15:0] alu_result_in,
   input  logic [15:0] wdata_in,
   input  logic        mem_rb,
   input  logic        mem_rw,
   input  logic        mem_wb,
   input  logic        mem_ww,
   output logic        bus_req,
   output logic        bus_we,
   output logic [15:0] bus_addr,
   output logic [15:0] bus_wdata,
   output logic [1:0]  bus_wstrb,
   input  logic [15:0] bus_rdata,
   input  logic        bus_ack,
   output logic        valid_out,
   output logic [15:0] result_out,
   output logic [31:0] control_signals_out,
   output logic [15:0] pc_out,
   output logic [1:0]  fault_out
);

   localparam int unsigned CNT_W = 16;

   localparam logic [1:0] FAULT_NONE    = 2'd0;
   localparam logic [1:0] FAULT_ALIGN   = 2'd1;
   localparam logic [1:0] FAULT_MULTI   = 2'd2;
   localparam logic [1:0] FAULT_TIMEOUT = 2'd3;

   typedef enum logic {IDLE, WAIT} state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               bus_req_q, bus_we_q, valid_q;
   logic [15:0]        bus_addr_q, bus_wdata_q, result_q, pc_q;
   logic [1:0]         bus_wstrb_q, fault_q;
   logic [31:0]        ctrl_q;

   // Decode of the memory-control flags for the instruction being offered
   logic [2:0]         nflags;
   logic               multi_flag, word_op, is_write, any_mem;
   logic [CNT_W:0]     cnt_next;
   logic [15:0]        load_data;

   always_comb begin
      nflags     = 3'(mem_rb) + 3'(mem_rw) + 3'(mem_wb) + 3'(mem_ww);
      multi_flag = (nflags > 3'd1);
      word_op    = mem_rw | mem_ww;
      is_write   = mem_wb | mem_ww;
      any_mem    = (nflags != 3'd0);
      // Counter value after this WAIT cycle; one bit wider so the compare cannot wrap
      cnt_next   = {1'b0, cnt_q} + 17'd1;
      // Word strobe pattern doubles as the word/byte marker for the in-flight read
      if (bus_wstrb_q == 2'b11)
         load_data = bus_rdata;
      else
         load_data = {8'h00, (bus_addr_q[0] ? bus_rdata[15:8] : bus_rdata[7:0])};
   end

   // Stage FSM and all registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         bus_wstrb_q <= '0;
         valid_q     <= 1'b0;
         result_q    <= '0;
         ctrl_q      <= '0;
         pc_q        <= '0;
         fault_q     <= FAULT_NONE;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (en) begin
                  pc_q   <= pc_in;
                  ctrl_q <= control_signals_in;
                  if (multi_flag) begin
                     result_q <= alu_result_in;
                     fault_q  <= FAULT_MULTI;
                     valid_q  <= 1'b1;
                  end else if (word_op && alu_result_in[0]) begin
                     result_q <= alu_result_in;
                     fault_q  <= FAULT_ALIGN;
                     valid_q  <= 1'b1;
                  end else if (any_mem) begin
                     bus_req_q  <= 1'b1;
                     bus_we_q   <= is_write;
                     bus_addr_q <= alu_result_in;
                     if (word_op) begin
                        bus_wstrb_q <= 2'b11;
                        bus_wdata_q <= wdata_in;
                     end else begin
                        bus_wstrb_q <= alu_result_in[0] ? 2'b10 : 2'b01;
                        bus_wdata_q <= {wdata_in[7:0], wdata_in[7:0]};
                     end
                     cnt_q   <= '0;
                     state_q <= WAIT;
                  end else begin
                     result_q <= alu_result_in;
                     fault_q  <= FAULT_NONE;
                     valid_q  <= 1'b1;
                  end
               end
            end
            WAIT: begin
               cnt_q <= cnt_next[CNT_W-1:0];
               // Ack takes priority over a coincident timeout
               if (bus_ack) begin
                  bus_req_q <= 1'b0;
                  result_q  <= bus_we_q ? bus_addr_q : load_data;
                  fault_q   <= FAULT_NONE;
                  valid_q   <= 1'b1;
                  state_q   <= IDLE;
               end else if (cnt_next >= 17'(TIMEOUT_CYCLES)) begin
                  bus_req_q <= 1'b0;
                  result_q  <= 16'h0000;
                  fault_q   <= FAULT_TIMEOUT;
                  valid_q   <= 1'b1;
                  state_q   <= IDLE;
               end
            end
         endcase
      end
   end

   assign stall               = (state_q == WAIT);
   assign bus_req             = bus_req_q;
   assign bus_we              = bus_we_q;
   assign bus_addr            = bus_addr_q;
   assign bus_wdata           = bus_wdata_q;
   assign bus_wstrb           = bus_wstrb_q;
   assign valid_out           = valid_q;
   assign result_out          = result_q;
   assign control_signals_out = ctrl_q;
   assign pc_out              = pc_q;
   assign fault_out           = fault_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed stimulus with a scoreboard queue; a monitor pops and
// compares each valid_out beat against the expected writeback payload.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        stall;
   logic [15:0] pc_in;
   logic [31:0] control_signals_in;
   logic [15:0] alu_result_in;
   logic [15:0] wdata_in;
   logic        mem_rb, mem_rw, mem_wb, mem_ww;
   logic        bus_req, bus_we;
   logic [15:0] bus_addr, bus_wdata;
   logic [1:0]  bus_wstrb;
   logic [15:0] bus_rdata;
   logic        bus_ack;
   logic        valid_out;
   logic [15:0] result_out;
   logic [31:0] control_signals_out;
   logic [15:0] pc_out;
   logic [1:0]  fault_out;

   typedef struct {
      logic [15:0] result;
      logic [1:0]  fault;
      logic [15:0] pc;
      logic [31:0] ctrl;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   mem_stage #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .en(en), .stall(stall),
      .pc_in(pc_in), .control_signals_in(control_signals_in),
      .alu_result_in(alu_result_in), .wdata_in(wdata_in),
      .mem_rb(mem_rb), .mem_rw(mem_rw), .mem_wb(mem_wb), .mem_ww(mem_ww),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
      .bus_rdata(bus_rdata), .bus_ack(bus_ack),
      .valid_out(valid_out), .result_out(result_out),
      .control_signals_out(control_signals_out), .pc_out(pc_out),
      .fault_out(fault_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   function automatic exp_t mk(input logic [15:0] r, input logic [1:0] f,
                               input logic [15:0] p, input logic [31:0] c);
      exp_t e;
      e.result = r; e.fault = f; e.pc = p; e.ctrl = c;
      return e;
   endfunction

   // Monitor: every valid_out beat must match the head of the scoreboard
   always @(negedge clk) begin
      if (!rst && valid_out) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_valid", 32'(result_out), 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("result_out", 32'(result_out), 32'(e.result));
            chk("fault_out", 32'(fault_out), 32'(e.fault));
            chk("pc_out", 32'(pc_out), 32'(e.pc));
            chk("ctrl_out", control_signals_out, e.ctrl);
         end
      end
   end

   // Offer one instruction for a single cycle; returns #1 after the accept edge
   task automatic issue(input logic [15:0] pc, input logic [31:0] ctrl,
                        input logic [15:0] alu, input logic [15:0] wd,
                        input logic [3:0] flags);
      @(negedge clk);
      en = 1'b1; pc_in = pc; control_signals_in = ctrl;
      alu_result_in = alu; wdata_in = wd;
      {mem_rb, mem_rw, mem_wb, mem_ww} = flags;
      @(posedge clk); #1;
      en = 1'b0; {mem_rb, mem_rw, mem_wb, mem_ww} = 4'b0000;
   endtask

   // Hold WAIT for k cycles; ack in the k-th when give_ack is set
   task automatic serve(input int k, input logic give_ack, input logic [15:0] rd,
                        input string name);
      for (int i = 0; i < k; i++) begin
         chk({name, "_stall"}, 32'(stall), 32'd1);
         chk({name, "_req"}, 32'(bus_req), 32'd1);
         if (give_ack && i == k - 1) begin
            bus_ack = 1'b1; bus_rdata = rd;
         end
         @(posedge clk); #1;
         bus_ack = 1'b0;
      end
      chk({name, "_stall_end"}, 32'(stall), 32'd0);
      chk({name, "_req_end"}, 32'(bus_req), 32'd0);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; pc_in = '0; control_signals_in = '0;
      alu_result_in = '0; wdata_in = '0;
      {mem_rb, mem_rw, mem_wb, mem_ww} = 4'b0000;
      bus_rdata = '0; bus_ack = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_outputs", {bus_req, bus_we, valid_out, stall, bus_wstrb, fault_out},
          32'd0);
      chk("rst_data", 32'(bus_addr | bus_wdata | result_out | pc_out), 32'd0);
      chk("rst_ctrl", control_signals_out, 32'd0);
      rst = 1'b0;

      // Pass-through
      exp_q.push_back(mk(16'h1234, 2'd0, 16'h0010, 32'hDEAD_0001));
      issue(16'h0010, 32'hDEAD_0001, 16'h1234, 16'h0000, 4'b0000);
      chk("pass_req", 32'(bus_req), 32'd0);
      chk("pass_stall", 32'(stall), 32'd0);

      // Word load, ack in the 3rd WAIT cycle
      exp_q.push_back(mk(16'hBEEF, 2'd0, 16'h0012, 32'h0000_0002));
      issue(16'h0012, 32'h0000_0002, 16'h0100, 16'h0000, 4'b0100);
      chk("wl_addr", 32'(bus_addr), 32'h0100);
      chk("wl_we", 32'(bus_we), 32'd0);
      chk("wl_strb", 32'(bus_wstrb), 32'd3);
      serve(3, 1'b1, 16'hBEEF, "wl");

      // Byte loads, high and low lane
      exp_q.push_back(mk(16'h00A5, 2'd0, 16'h0014, 32'h0000_0003));
      issue(16'h0014, 32'h0000_0003, 16'h0101, 16'h0000, 4'b1000);
      chk("bl_hi_strb", 32'(bus_wstrb), 32'd2);
      serve(1, 1'b1, 16'hA55A, "bl_hi");
      exp_q.push_back(mk(16'h005A, 2'd0, 16'h0016, 32'h0000_0004));
      issue(16'h0016, 32'h0000_0004, 16'h0100, 16'h0000, 4'b1000);
      chk("bl_lo_strb", 32'(bus_wstrb), 32'd1);
      serve(2, 1'b1, 16'hA55A, "bl_lo");

      // Byte store to odd address
      exp_q.push_back(mk(16'h0203, 2'd0, 16'h0018, 32'h0000_0005));
      issue(16'h0018, 32'h0000_0005, 16'h0203, 16'h12CD, 4'b0010);
      chk("bs_strb", 32'(bus_wstrb), 32'd2);
      chk("bs_wdata", 32'(bus_wdata), 32'hCDCD);
      chk("bs_we", 32'(bus_we), 32'd1);
      serve(1, 1'b1, 16'hFFFF, "bs");

      // Word store
      exp_q.push_back(mk(16'h0204, 2'd0, 16'h001A, 32'h0000_0006));
      issue(16'h001A, 32'h0000_0006, 16'h0204, 16'h1234, 4'b0001);
      chk("ws_strb", 32'(bus_wstrb), 32'd3);
      chk("ws_wdata", 32'(bus_wdata), 32'h1234);
      serve(2, 1'b1, 16'h0000, "ws");

      // Misaligned word write and illegal multi-flag
      exp_q.push_back(mk(16'h0011, 2'd1, 16'h001C, 32'h0000_0007));
      issue(16'h001C, 32'h0000_0007, 16'h0011, 16'h5555, 4'b0001);
      chk("mis_req", 32'(bus_req), 32'd0);
      exp_q.push_back(mk(16'h0040, 2'd2, 16'h001E, 32'h0000_0008));
      issue(16'h001E, 32'h0000_0008, 16'h0040, 16'h0000, 4'b1010);
      chk("multi_req", 32'(bus_req), 32'd0);

      // Timeout after 4 WAIT cycles
      exp_q.push_back(mk(16'h0000, 2'd3, 16'h0020, 32'h0000_0009));
      issue(16'h0020, 32'h0000_0009, 16'h0300, 16'h0000, 4'b0100);
      serve(4, 1'b0, 16'h0000, "tmo");

      // Back-to-back pass-through
      exp_q.push_back(mk(16'hAAAA, 2'd0, 16'h0022, 32'h0000_000A));
      exp_q.push_back(mk(16'hBBBB, 2'd0, 16'h0024, 32'h0000_000B));
      @(negedge clk);
      en = 1'b1; pc_in = 16'h0022; control_signals_in = 32'h0000_000A;
      alu_result_in = 16'hAAAA;
      @(posedge clk); #1;
      pc_in = 16'h0024; control_signals_in = 32'h0000_000B; alu_result_in = 16'hBBBB;
      @(posedge clk); #1;
      en = 1'b0;

      // Reset in WAIT: bus_req drops immediately, instruction discarded
      issue(16'h0026, 32'h0000_000C, 16'h0400, 16'h0000, 4'b0100);
      chk("rstw_req_before", 32'(bus_req), 32'd1);
      rst = 1'b1; #1;
      chk("rstw_req", 32'(bus_req), 32'd0);
      chk("rstw_stall", 32'(stall), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp_q.push_back(mk(16'h0077, 2'd0, 16'h0028, 32'h0000_000D));
      issue(16'h0028, 32'h0000_000D, 16'h0401, 16'h0000, 4'b1000);
      serve(1, 1'b1, 16'h7700, "post_rst");

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Watchdog against a stuck run
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
